calc_req_sequencer: RTL
=======================

// Module: calc_req_sequencer
// PURPOSE
// - Upstream request driver for one calc1_top channel (reqN_cmd_in/reqN_data_in, out_respN/out_dataN).
// - Queues {tag,cmd,op1,op2} requests from a valid/ready source and serialises each to the calculator.
// - Serial protocol: cmd+op1 in one cycle, then cmd=0 with op2 in the next cycle.
// - Waits for the nonzero response pulse and returns {resp,data,tag} on a valid/ready result port.
// - Instantiate one per channel (four per calc1_top).
// PARAMETERS
// - DEPTH        4   request FIFO entries; power of two, >=2
// - TAG_W        4   width of the caller tag carried with each request
// - TIMEOUT_CYC  10  WAIT-state cycles before timeout; used only with CALC_REQ_TIMEOUT_EN
// PORTS
// - c_clk         in   1        clock, all logic on posedge
// - reset         in   1        synchronous, active-high
// - in_valid      in   1        request valid
// - in_ready      out  1        request accepted when in_valid&&in_ready
// - in_cmd        in   4        0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others passed through
// - in_op1        in   32       operand 1
// - in_op2        in   32       operand 2
// - in_tag        in   TAG_W    caller tag, returned unchanged
// - req_cmd_out   out  4        to reqN_cmd_in
// - req_data_out  out  32       to reqN_data_in
// - calc_resp_in  in   2        from out_respN; 0 none, 1 ok, 2 over/underflow, 3 invalid cmd
// - calc_data_in  in   32       from out_dataN
// - rsp_valid     out  1        result valid
// - rsp_ready     in   1        result consumed when rsp_valid&&rsp_ready
// - rsp_resp      out  2        captured response code
// - rsp_data      out  32       captured result data
// - rsp_tag       out  TAG_W    tag of the completed request
// - rsp_timeout   out  1        completion caused by timeout
// - stray_resp    out  1        sticky: nonzero calc_resp_in seen outside WAIT
// - fifo_count    out  $clog2(DEPTH+1)  queued requests
// BEHAVIOUR
// - Reset (sync, high): FSM=IDLE, FIFO emptied, all outputs 0 (in_ready=0 while reset=1, 1 the cycle after).
// - Reset mid-operation abandons the request; no result is produced.
// - FIFO: in_ready=!full; push on handshake; no push when full.
// - fifo_count updates the cycle after push/pop; simultaneous push+pop leaves count unchanged.
// - FSM IDLE: if count>0, pop into working regs. cmd==0 -> DONE (resp=0, data=0, never sent to calc); else -> OP1.
// - FSM OP1 (1 cycle): req_cmd_out=cmd, req_data_out=op1 -> OP2.
// - FSM OP2 (1 cycle): req_cmd_out=0, req_data_out=op2 -> WAIT.
// - FSM WAIT: req_cmd_out=0, req_data_out=0.
//   On the first cycle calc_resp_in!=0, capture resp/data -> DONE (the calc response is a 1-cycle pulse).
// - FSM DONE: rsp_valid=1; rsp_* held stable until rsp_ready; on handshake -> IDLE, rsp_valid=0 next cycle.
// - Requests drive outputs only in OP1/OP2; req_* are registered and are 0 in every other state.
// - Latency: push at edge k with an empty idle FSM -> OP1 visible after edge k+2, OP2 after k+3, WAIT from k+4.
// - Latency: response sampled at edge m -> rsp_valid high after edge m+1.
// - No result reordering; one request is in flight at a time; the next pop happens only from IDLE.
// - Calculator response in IDLE/OP1/OP2/DONE is ignored and sets stray_resp (cleared only by reset).
// - Operands pass through unmodified; no arithmetic is performed here.
// CONFIGURATION
// - Macro CALC_REQ_TIMEOUT_EN defined:
//   WAIT counter counts 1..TIMEOUT_CYC; at TIMEOUT_CYC with no response -> DONE with resp=0, data=0, rsp_timeout=1.
//   A response arriving on the same cycle the counter reaches TIMEOUT_CYC wins (rsp_timeout=0).
//   Counter clears on entry to WAIT.
// - Macro CALC_REQ_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; rsp_timeout tied 0.
// TESTING
// - add: in {cmd=1,op1=5,op2=1,tag=3}; calc model returns resp=1, data=6 ->
//   req sees (1,5) then (0,1); result {1,6,tag 3}.
// - overflow: {cmd=1,op1=FFFFFFFF,op2=1}, model resp=2 -> rsp_resp=2, tag preserved.
// - no-op: {cmd=0,tag=7} -> req_cmd_out stays 0, result {0,0,tag 7} with no calc activity.
// - backpressure: push 5 reqs with DEPTH=4 and rsp_ready=0 ->
//   in_ready=0 at count 4; results in order 0..4 once rsp_ready=1; data held stable while stalled.
// - reset in WAIT: assert reset 1 cycle -> all outputs 0, no result.
//   Late calc resp=1 then sets stray_resp=1.
// - timeout (macro on): cmd=6, no calc response -> after 10 WAIT cycles result {0,0}, rsp_timeout=1.

Source files
------------

// File: rtl/calc_req_sequencer_if.sv
// calc_req_sequencer_if: request and result valid/ready bundles
// for one calc channel sequencer.
interface calc_req_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cmd;
  logic [31:0]      in_op1;
  logic [31:0]      in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_resp;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  modport master (
    output in_valid, in_cmd, in_op1, in_op2, in_tag, rsp_ready,
    input  in_ready, rsp_valid, rsp_resp, rsp_data, rsp_tag,
           rsp_timeout
  );

  modport slave (
    input  in_valid, in_cmd, in_op1, in_op2, in_tag, rsp_ready,
    output in_ready, rsp_valid, rsp_resp, rsp_data, rsp_tag,
           rsp_timeout
  );
endinterface

// File: rtl/calc_req_sequencer.sv
// calc_req_sequencer: queues tagged requests, serialises them to one calc channel.
// Define CALC_REQ_TIMEOUT_EN to abandon WAIT after TIMEOUT_CYC cycles.
module calc_req_sequencer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 10
) (
  input  logic                       c_clk,
  input  logic                       reset,
  calc_req_sequencer_if.slave        rq,
  output logic [3:0]                 req_cmd_out,
  output logic [31:0]                req_data_out,
  input  logic [1:0]                 calc_resp_in,
  input  logic [31:0]                calc_data_in,
  output logic                       stray_resp,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAG_W + 4 + 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1,
    S_OP2,
    S_WAIT,
    S_DONE
  } st_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("calc_req_sequencer: bad parameters");
  end

  st_e              r_st;
  st_e              w_nxt;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_cmd;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [3:0]       r_req_cmd;
  logic [31:0]      r_req_data;
  logic             r_rsp_valid;
  logic [1:0]       r_resp;
  logic [31:0]      r_data;
  logic             r_to;
  logic             r_stray;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_cap;
  logic             w_to;
  logic             w_tmo;
  logic [EW-1:0]    w_head;
  logic [3:0]       w_head_cmd;

  // entry layout {tag, cmd, op1, op2}
  assign w_head     = r_mem[r_rp];
  assign w_head_cmd = w_head[67:64];
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_push     = rq.in_valid && rq.in_ready;
  assign w_pop      = (r_st == S_IDLE) && (r_cnt != '0);
  assign w_hs       = r_rsp_valid && rq.rsp_ready;

  assign rq.in_ready    = !reset && !w_full;
  assign rq.rsp_valid   = r_rsp_valid;
  assign rq.rsp_resp    = r_resp;
  assign rq.rsp_data    = r_data;
  assign rq.rsp_tag     = r_tag;
  assign rq.rsp_timeout = r_to;
  assign req_cmd_out    = r_req_cmd;
  assign req_data_out   = r_req_data;
  assign stray_resp     = r_stray;
  assign fifo_count     = r_cnt;

`ifdef CALC_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wcnt;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (r_st != S_WAIT) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + TW'(1);
    end
  end

  assign w_tmo = (r_st == S_WAIT) &&
                 (r_wcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {rq.in_tag, rq.in_cmd,
                      rq.in_op1, rq.in_op2};
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_st <= S_IDLE;
    end else begin
      r_st <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_st;
    w_cap = 1'b0;
    w_to  = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (w_pop) begin
          w_nxt = (w_head_cmd == 4'd0) ? S_DONE : S_OP1;
        end
      end
      S_OP1: w_nxt = S_OP2;
      S_OP2: w_nxt = S_WAIT;
      // a response on the timeout cycle takes priority
      S_WAIT: begin
        if (calc_resp_in != 2'd0) begin
          w_cap = 1'b1;
          w_nxt = S_DONE;
        end else if (w_tmo) begin
          w_to  = 1'b1;
          w_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_hs) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_tag       <= '0;
      r_cmd       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_req_cmd   <= '0;
      r_req_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_resp      <= '0;
      r_data      <= '0;
      r_to        <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_tag, r_cmd, r_op1, r_op2} <= w_head;
        r_resp <= '0;
        r_data <= '0;
        r_to   <= 1'b0;
      end
      if (w_cap) begin
        r_resp <= calc_resp_in;
        r_data <= calc_data_in;
      end
      if (w_to) r_to <= 1'b1;
      unique case (1'b1)
        (r_st == S_OP1): begin
          r_req_cmd  <= r_cmd;
          r_req_data <= r_op1;
        end
        (r_st == S_OP2): begin
          r_req_cmd  <= 4'd0;
          r_req_data <= r_op2;
        end
        default: begin
          r_req_cmd  <= 4'd0;
          r_req_data <= 32'd0;
        end
      endcase
      r_rsp_valid <= (r_st == S_DONE) && !w_hs;
      if (r_st != S_WAIT && calc_resp_in != 2'd0) begin
        r_stray <= 1'b1;
      end
    end
  end
endmodule
